rx_serial_7e1: RTL and testbench
================================

# rx_serial_7E1

Asynchronous serial receiver for 7E1 frames: idle line at '1', one start bit '0', 7 data bits LSB first, even parity bit, one stop bit '1'. The block is the receiving end of the link fed by the 7E1 transmitter. It generates its own bit timing from the system clock and samples each bit at mid-period. It delivers the decoded ASCII character with a one-cycle `pronto` strobe plus parity and framing error flags.

## Interface
- `M`, default 434: clock cycles per bit period (50 MHz / 115200 baud); minimum 4.
- `N`, default 9: width of the bit-timing counter; must satisfy 2^N > M.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high; returns FSM and outputs to reset values.
- `dado_serial`  in  1  serial line, idle '1'.
- `dados_ascii`  out  7  last received character, bit 0 = first data bit on the line.
- `paridade_ok`  out  1  '1' when data bits plus parity bit contain an even number of '1's.
- `erro_stop`  out  1  '1' when the stop bit was sampled as '0'.
- `pronto`  out  1  one-cycle strobe; frame complete, outputs valid.
- `ocupado`  out  1  '1' from start-bit detection until `pronto`.
- `db_estado`  out  4  current FSM state encoding, for debug.

## Operation
- FSM states:
  - `inicial`: entered on reset. Clears the datapath, then goes to `repouso`.
  - `repouso`: waits for line = '1' (prevents a false start when the line is low at reset or after a framing error), then goes to `espera_start`.
  - `espera_start`: line = '0' → `confirma_start`, counter cleared.
  - `confirma_start`: waits M/2 cycles (integer division), then samples the line. '0' → `recebe`, counter cleared. '1' → glitch, back to `espera_start` with no output change.
  - `recebe`: every M cycles, samples the line and shifts it into an 8-bit shift register from the MSB side. After 8 samples (7 data + parity) → `stop`.
  - `stop`: waits M cycles, then samples the stop bit → `final`.
  - `final`: registers `dados_ascii`, `paridade_ok` and `erro_stop`, pulses `pronto`. Goes to `espera_start` if the stop bit was '1', otherwise to `repouso`.
- Outputs hold their values until the next `final`. An errored frame still updates `dados_ascii`.
- Parity check: `paridade_ok` = ~^{parity bit, data[6:0]}.
- Counter wrap-around: the counter runs 0..M-1 and is cleared at every state entry. It never free-runs across frames.

## Timing
- Reset value of every output is 0. `db_estado` reads the `inicial` encoding.
- Let t be the first cycle `dado_serial` is seen low in `espera_start`.
- Sample times:
  - start bit at t+M/2;
  - data bit k (k = 0..6) at t+M/2+(k+1)·M;
  - parity at t+M/2+8·M;
  - stop at t+M/2+9·M.
- `pronto` is high for exactly one cycle, at t+M/2+9·M+1. Outputs are valid in that same cycle.
- `ocupado` rises at t+1 and falls with `pronto`.
- Back-to-back frames are accepted: a start edge arriving ½ bit after the stop sample is detected.
- Reset asserted mid-frame wins over all other activity: the next cycle is `inicial` with all outputs 0, and no `pronto` is issued.
- Line low for fewer than M/2 cycles produces no `pronto`.

## Configuration
- `RX_SERIAL_7E1_SYNC_EN`
  - Defined: `dado_serial` passes through a two-flop synchronizer reset to '1'. All timing above shifts by +2 cycles relative to the pin.
  - Undefined: `dado_serial` is used directly. The input is assumed already synchronous to `clock`.

## Structure
- Shared package `serial_7E1_pkg` holds:
  - FSM state encodings (4-bit);
  - frame constants: 7 data bits, 8 shifted bits, 1 stop bit;
  - default `M` for 115200 baud. The transmitter uses the same package.
- Sub-module `rx_serial_7E1_uc` holds the control FSM.
- The datapath stays in the top and reuses the existing `contador_m` for bit timing and `deslocador_n` (N=8) for bit collection.

## Test plan
Bench uses M=8 and the macro undefined.
- Send 'A' (7'h41, parity 0, stop 1) → `pronto` one cycle at t+4+72+1, `dados_ascii`=7'h41, `paridade_ok`=1, `erro_stop`=0.
- Send 7'h43 with parity bit 0 → `dados_ascii`=7'h43, `paridade_ok`=0.
- Send 7'h41 with stop bit 0 → `erro_stop`=1. FSM then stays in `repouso` until the line returns to '1`, and no `pronto` occurs while the line is held low.
- Line low for 2 cycles then high → no `pronto`, `ocupado` pulses and returns to 0, FSM back in `espera_start`.
- Assert `reset` during data bit 3 of a frame → all outputs 0 next cycle. A following clean 7'h5A frame is received correctly.
- Frames 7'h30 and 7'h7F sent back-to-back with a single stop bit → two `pronto` strobes 10·M cycles apart, correct data on each.

Source files
------------

// File: rtl/serial_7e1_pkg.sv
// ---------------------------------------------------------------------------
// serial_7e1_pkg
// Definitions shared by the 7E1 serial transmitter and receiver:
//   - estado_t      : 4-bit FSM state encodings of the receiver control unit
//   - NUM_DADOS     : data bits per frame (7)
//   - NUM_DESLOC    : bits collected by the shift register (7 data + parity)
//   - NUM_STOP      : stop bits per frame (1)
//   - M_115200      : clock cycles per bit at 50 MHz / 115200 baud
//   - paridade_par  : even-parity check over data plus parity bit
// ---------------------------------------------------------------------------
package serial_7e1_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL        = 4'd0,
        ST_REPOUSO        = 4'd1,
        ST_ESPERA_START   = 4'd2,
        ST_CONFIRMA_START = 4'd3,
        ST_RECEBE         = 4'd4,
        ST_STOP           = 4'd5,
        ST_FINAL          = 4'd6
    } estado_t;

    localparam int NUM_DADOS  = 7;
    localparam int NUM_DESLOC = NUM_DADOS + 1;
    localparam int NUM_STOP   = 1;
    localparam int M_115200   = 434;

    // '1' when the 8 collected bits hold an even number of ones.
    function automatic logic paridade_par(input logic [NUM_DESLOC-1:0] bits);
        return ~^bits;
    endfunction

endpackage

// File: rtl/contador_m.sv
// ---------------------------------------------------------------------------
// contador_m
// Modulo-M bit-timing counter, runs 0..M-1 while enabled.
//   clock, reset : system clock, synchronous active-high reset
//   zera         : clear to 0 (priority over conta)
//   conta        : count enable
//   fim          : count is at M-1 (end of a bit period)
//   meio         : count is at M/2-1 (middle of a bit, from a cleared start)
// ---------------------------------------------------------------------------
module contador_m #(
    parameter int M = 434,
    parameter int N = 9
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim,
    output logic meio
);

    logic [N-1:0] q;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clock) begin
        if (reset || zera)
            q <= '0;
        else if (conta)
            q <= (q == N'(M - 1)) ? '0 : q + N'(1);
    end

    assign fim  = (q == N'(M - 1));
    assign meio = (q == N'(M / 2 - 1));

endmodule

// File: rtl/deslocador_n.sv
// ---------------------------------------------------------------------------
// deslocador_n
// N-bit shift register filled from the MSB side, so after N shifts the first
// bit received sits in bit 0.
//   clock, reset : system clock, synchronous active-high reset
//   limpa        : clear contents
//   desloca      : shift 'entrada' in at the MSB
//   entrada      : serial input bit
//   dados        : register contents
// ---------------------------------------------------------------------------
module deslocador_n #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         limpa,
    input  logic         desloca,
    input  logic         entrada,
    output logic [N-1:0] dados
);

    always_ff @(posedge clock) begin
        if (reset || limpa)
            dados <= '0;
        else if (desloca)
            dados <= {entrada, dados[N-1:1]};
    end

endmodule

// File: rtl/rx_serial_7e1_uc.sv
// ---------------------------------------------------------------------------
// rx_serial_7e1_uc
// Control FSM of the 7E1 receiver.
//   clock, reset : system clock, synchronous active-high reset
//   linha        : (possibly synchronised) serial line
//   fim_bit      : bit counter at M-1
//   meio_bit     : bit counter at M/2-1
//   stop_erro    : registered framing-error flag from the datapath
//   zera_cnt     : clear the bit counter (asserted on every state entry)
//   conta        : bit counter enable
//   desloca      : shift the line into the shift register
//   registra     : load output registers (stop-bit sample cycle)
//   limpa        : clear the datapath
//   pronto       : registered one-cycle frame-complete strobe
//   ocupado      : registered busy flag, start detection until pronto
//   db_estado    : current state encoding
// ---------------------------------------------------------------------------
module rx_serial_7e1_uc
    import serial_7e1_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       linha,
    input  logic       fim_bit,
    input  logic       meio_bit,
    input  logic       stop_erro,
    output logic       zera_cnt,
    output logic       conta,
    output logic       desloca,
    output logic       registra,
    output logic       limpa,
    output logic       pronto,
    output logic       ocupado,
    output logic [3:0] db_estado
);

    estado_t    estado;
    logic [2:0] n_bits;
    logic       ultimo_bit;

    assign ultimo_bit = (n_bits == 3'(NUM_DESLOC - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= ST_INICIAL;
            n_bits  <= '0;
            pronto  <= 1'b0;
            ocupado <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                ST_INICIAL: estado <= ST_REPOUSO;

                // A line held low here (reset or after a framing error) must
                // not be mistaken for a start bit.
                ST_REPOUSO: if (linha) estado <= ST_ESPERA_START;

                ST_ESPERA_START: begin
                    if (!linha) begin
                        estado  <= ST_CONFIRMA_START;
                        ocupado <= 1'b1;
                    end
                end

                ST_CONFIRMA_START: begin
                    if (meio_bit) begin
                        if (!linha) begin
                            estado <= ST_RECEBE;
                            n_bits <= '0;
                        end else begin
                            // Glitch shorter than half a bit: drop it silently.
                            estado  <= ST_ESPERA_START;
                            ocupado <= 1'b0;
                        end
                    end
                end

                ST_RECEBE: begin
                    if (fim_bit) begin
                        n_bits <= n_bits + 3'd1;
                        if (ultimo_bit) estado <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (fim_bit) begin
                        estado  <= ST_FINAL;
                        pronto  <= 1'b1;
                        ocupado <= 1'b0;
                    end
                end

                ST_FINAL: estado <= stop_erro ? ST_REPOUSO : ST_ESPERA_START;

                default: estado <= ST_INICIAL;
            endcase
        end
    end

    // Datapath strobes decoded from the current state and counter flags.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        zera_cnt = 1'b0;
        conta    = 1'b0;
        desloca  = 1'b0;
        registra = 1'b0;
        limpa    = 1'b0;
        case (estado)
            ST_INICIAL: limpa = 1'b1;
            ST_CONFIRMA_START: begin
                conta    = 1'b1;
                zera_cnt = meio_bit;
            end
            ST_RECEBE: begin
                conta    = 1'b1;
                desloca  = fim_bit;
                zera_cnt = fim_bit && ultimo_bit;
            end
            ST_STOP: begin
                conta    = 1'b1;
                registra = fim_bit;
            end
            default: zera_cnt = 1'b1;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: rtl/rx_serial_7e1.sv
// ---------------------------------------------------------------------------
// rx_serial_7e1
// Asynchronous serial receiver for 7E1 frames (start, 7 data LSB first, even
// parity, 1 stop). Bit timing is generated locally; each bit is sampled at
// mid-period.
//   M, N         : cycles per bit (>= 4), bit counter width (2^N > M)
//   clock        : system clock, rising edge
//   reset        : synchronous, active-high
//   dado_serial  : serial line, idle '1'
//   dados_ascii  : last received character (bit 0 = first data bit)
//   paridade_ok  : data plus parity bit hold an even number of ones
//   erro_stop    : stop bit was sampled as '0'
//   pronto       : one-cycle strobe, outputs valid
//   ocupado      : start detection until pronto
//   db_estado    : FSM state encoding
// Build option: define RX_SERIAL_7E1_SYNC_EN to pass dado_serial through a
// two-flop synchroniser (all timing shifts by +2 cycles from the pin).
// ---------------------------------------------------------------------------
module rx_serial_7e1
    import serial_7e1_pkg::*;
#(
    parameter int M = M_115200,
    parameter int N = 9
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 dado_serial,
    output logic [NUM_DADOS-1:0] dados_ascii,
    output logic                 paridade_ok,
    output logic                 erro_stop,
    output logic                 pronto,
    output logic                 ocupado,
    output logic [3:0]           db_estado
);

    logic                  linha;
    logic                  zera_cnt, conta, desloca, registra, limpa;
    logic                  fim_bit, meio_bit;
    logic [NUM_DESLOC-1:0] desloc;

`ifdef RX_SERIAL_7E1_SYNC_EN
    // Reset to the idle level so leaving reset never looks like a start bit.
    logic [1:0] sincr;
    always_ff @(posedge clock) begin
        if (reset)
            sincr <= 2'b11;
        else
            sincr <= {sincr[0], dado_serial};
    end
    assign linha = sincr[1];
`else
    assign linha = dado_serial;
`endif

    contador_m #(.M(M), .N(N)) u_contador (
        .clock (clock),
        .reset (reset),
        .zera  (zera_cnt | limpa),
        .conta (conta),
        .fim   (fim_bit),
        .meio  (meio_bit)
    );

    deslocador_n #(.N(NUM_DESLOC)) u_deslocador (
        .clock   (clock),
        .reset   (reset),
        .limpa   (limpa),
        .desloca (desloca),
        .entrada (linha),
        .dados   (desloc)
    );

    rx_serial_7e1_uc u_uc (
        .clock     (clock),
        .reset     (reset),
        .linha     (linha),
        .fim_bit   (fim_bit),
        .meio_bit  (meio_bit),
        .stop_erro (erro_stop),
        .zera_cnt  (zera_cnt),
        .conta     (conta),
        .desloca   (desloca),
        .registra  (registra),
        .limpa     (limpa),
        .pronto    (pronto),
        .ocupado   (ocupado),
        .db_estado (db_estado)
    );

    // Loaded on the stop-bit sample edge so the values are valid in the same
    // cycle as pronto; held until the next frame completes.
    always_ff @(posedge clock) begin
        if (reset) begin
            dados_ascii <= '0;
            paridade_ok <= 1'b0;
            erro_stop   <= 1'b0;
        end else if (registra) begin
            dados_ascii <= desloc[NUM_DADOS-1:0];
            paridade_ok <= paridade_par(desloc);
            erro_stop   <= ~linha;
        end
    end

endmodule

// File: tb/tb_rx_serial_7e1.sv
`timescale 1ns/1ps
module tb_rx_serial_7e1;
    import serial_7e1_pkg::*;

    localparam int M   = 8;
    localparam int N   = 4;
    localparam int LAT = M / 2 + 9 * M + 1;   // start edge to pronto

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dado_serial = 1'b1;
    logic [6:0] dados_ascii;
    logic       paridade_ok, erro_stop, pronto, ocupado;
    logic [3:0] db_estado;

    rx_serial_7e1 #(.M(M), .N(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .dado_serial (dado_serial),
        .dados_ascii (dados_ascii),
        .paridade_ok (paridade_ok),
        .erro_stop   (erro_stop),
        .pronto      (pronto),
        .ocupado     (ocupado),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int         cyc;
        logic [6:0] data;
        logic       par_ok;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    logic [6:0] m_data = '0;
    logic       m_par = 1'b0, m_err = 1'b0;
    int         busy_from = -1, busy_to = -1;
    bit         chk_en = 1'b0;
    logic       exp_p;
    exp_t       head;

    int         n_pronto = 0;
    int         pr_cyc[$];
    logic [6:0] pr_data[$];
    logic       last_par, last_err;

    // A frame whose start edge the receiver sees at cycle t.
    task automatic expect_frame(input int t, input logic [6:0] d, input logic p, input logic s);
        exp_t e;
        e.cyc    = t + LAT;
        e.data   = d;
        e.par_ok = ($countones({p, d}) % 2 == 0);
        e.err    = ~s;
        exp_q.push_back(e);
        busy_from = t;
        busy_to   = t + LAT;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("pronto_deadline", cyc, exp_q[0].cyc);
                head = exp_q.pop_front();
            end
            exp_p = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                head   = exp_q.pop_front();
                exp_p  = 1'b1;
                m_data = head.data;
                m_par  = head.par_ok;
                m_err  = head.err;
            end
            check("pronto", pronto, exp_p);
            check("dados_ascii", dados_ascii, m_data);
            check("paridade_ok", paridade_ok, m_par);
            check("erro_stop", erro_stop, m_err);
            check("ocupado", ocupado, (cyc > busy_from && cyc < busy_to));
            if (pronto === 1'b1) begin
                n_pronto++;
                pr_cyc.push_back(cyc);
                pr_data.push_back(dados_ascii);
                last_par = paridade_ok;
                last_err = erro_stop;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_frame(input logic [6:0] d, input logic p, input logic s);
        logic [9:0] bits;
        bits = {s, p, d, 1'b0};
        expect_frame(cyc, d, p, s);
        for (int i = 0; i < 10; i++) begin
            dado_serial = bits[i];
            tick(M);
        end
    endtask

    function automatic logic even_par(input logic [6:0] d);
        return ^d;
    endfunction

    int         t0, np;
    logic [6:0] rd;
    logic [9:0] rbits;
    int         kind, len;

    initial begin
        tick(3);
        check("rst_dados", dados_ascii, 7'h00);
        check("rst_flags", {paridade_ok, erro_stop, pronto, ocupado}, 4'b0000);
        check("rst_estado", db_estado, ST_INICIAL);
        reset  = 1'b0;
        chk_en = 1'b1;
        tick(4);
        check("idle_estado", db_estado, ST_ESPERA_START);

        // 'A': pronto exactly 4+72+1 cycles after the start edge
        t0 = cyc;
        send_frame(7'h41, 1'b0, 1'b1);
        check("A_latency", pr_cyc[$] - t0, 77);
        check("A_data", pr_data[$], 7'h41);
        check("A_flags", {last_par, last_err}, 2'b10);
        tick(3);

        // 7'h43 with a wrong parity bit
        send_frame(7'h43, 1'b0, 1'b1);
        check("bad_par_data", pr_data[$], 7'h43);
        check("bad_par_flag", last_par, 1'b0);
        tick(2);

        // framing error, line then held low
        send_frame(7'h41, 1'b0, 1'b0);
        check("ferr_flag", last_err, 1'b1);
        np = n_pronto;
        tick(3 * M);
        check("ferr_hold_estado", db_estado, ST_REPOUSO);
        check("ferr_no_pronto", n_pronto, np);
        dado_serial = 1'b1;
        tick(2);
        check("ferr_release_estado", db_estado, ST_ESPERA_START);
        tick(2);

        // short glitch: low 2 cycles
        np = n_pronto;
        busy_from = cyc;
        busy_to   = cyc + M / 2 + 1;
        dado_serial = 1'b0;
        tick(2);
        dado_serial = 1'b1;
        tick(2 * M);
        check("glitch_no_pronto", n_pronto, np);
        check("glitch_estado", db_estado, ST_ESPERA_START);

        // reset during data bit 3 (cycles t+32..t+39)
        t0 = cyc;
        expect_frame(t0, 7'h15, 1'b1, 1'b1);
        rbits = {1'b1, 1'b1, 7'h15, 1'b0};
        for (int i = 0; i < 4; i++) begin
            dado_serial = rbits[i];
            tick(M);
        end
        dado_serial = rbits[4];
        tick(3);
        reset = 1'b1;
        tick(1);
        exp_q.delete();
        busy_from = -1;
        busy_to   = -1;
        m_data = '0;
        m_par  = 1'b0;
        m_err  = 1'b0;
        check("midrst_estado", db_estado, ST_INICIAL);
        check("midrst_dados", dados_ascii, 7'h00);
        check("midrst_flags", {paridade_ok, erro_stop, pronto, ocupado}, 4'b0000);
        reset = 1'b0;
        dado_serial = 1'b1;
        tick(4);
        t0 = cyc;
        send_frame(7'h5A, 1'b0, 1'b1);
        check("post_rst_latency", pr_cyc[$] - t0, 77);
        check("post_rst_data", pr_data[$], 7'h5A);
        check("post_rst_par", last_par, 1'b1);

        // back-to-back frames
        np = n_pronto;
        send_frame(7'h30, 1'b0, 1'b1);
        send_frame(7'h7F, 1'b1, 1'b1);
        check("b2b_count", n_pronto - np, 2);
        check("b2b_spacing", pr_cyc[$] - pr_cyc[$-1], 80);
        check("b2b_data0", pr_data[$-1], 7'h30);
        check("b2b_data1", pr_data[$], 7'h7F);
        tick(3);

        // randomized traffic against the model
        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 9);
            rd   = 7'($urandom);
            if (kind == 0) begin
                len = $urandom_range(1, M / 2 - 1);
                busy_from = cyc;
                busy_to   = cyc + M / 2 + 1;
                dado_serial = 1'b0;
                tick(len);
                dado_serial = 1'b1;
                tick(M - len);
            end else if (kind == 1) begin
                send_frame(rd, even_par(rd), 1'b0);
                dado_serial = 1'b1;
                tick(3 + $urandom_range(0, M));
            end else begin
                send_frame(rd, even_par(rd) ^ ($urandom_range(0, 3) == 0), 1'b1);
                tick($urandom_range(0, M));
            end
        end

        tick(LAT + 5);
        check("model_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
